// File: rtl/tff_mod_counter_pkg.sv
// Shared types for the T-flip-flop modulo counter: the per-edge operation
// selected from the load/enable/direction strobes.
package tff_mod_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  // Load outranks enable; direction only matters once the counter is enabled.
  function automatic op_e decodeOp(input logic load, input logic en, input logic up);
    op_e op;
    if (load)    op = OP_LOAD;
    else if (en) op = up ? OP_INC : OP_DEC;
    else         op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single T flip-flop: a D flip-flop whose input is the toggle XOR the
// current state, with a per-instance asynchronous reset value.
module tff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic t,
  input  logic clk,
  input  logic reset,
  output logic q,
  output logic qn
);

  logic state_q;
  logic state_d;

  assign state_d = t ^ state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RST_BIT;
    else       state_q <= state_d;
  end

  assign q  = state_q;
  assign qn = ~state_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Up/down modulo counter built from a bank of T flip-flops, with load,
// enable, optional saturation, terminal count and a registered wrap pulse.
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 2 ** WIDTH,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1) begin : gBadWidth
    $error("tff_mod_counter: WIDTH must be at least 1");
  end
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : gBadModulus
    $error("tff_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : gBadReset
    $error("tff_mod_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] countN;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] toggleVec;
  logic             wrap_d;
  logic             wrap_q;

  // Every state change is expressed as per-bit toggles into the T cells.
  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    tff_cell #(
      .RST_BIT (RST_VEC[i])
    ) uCell (
      .t     (toggleVec[i]),
      .clk   (clk),
      .reset (reset),
      .q     (count[i]),
      .qn    (countN[i])
    );
  end

  always_comb begin
    next_d = count;
    wrap_d = 1'b0;
    unique case (decodeOp(load, en, up))
      OP_LOAD: begin
        next_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAXV;
      end
      OP_INC: begin
        if (count == MAXV) begin
          if (!SATURATE) begin
            next_d = '0;
            wrap_d = 1'b1;
          end
        end else begin
          next_d = count + ONE;
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          if (!SATURATE) begin
            next_d = MAXV;
            wrap_d = 1'b1;
          end
        end else begin
          next_d = count - ONE;
        end
      end
      default: begin
        next_d = count;
      end
    endcase
  end

  assign toggleVec = count ^ next_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign q    = count;
  assign qn   = countN;
  assign tc   = (up && (count == MAXV)) || (!up && (count == '0));
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed testbench for tff_mod_counter: wrapping mod-10, saturating mod-10
// and power-of-two mod-8 instances sharing one clock and reset.
module tb_tff_mod_counter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic       aEn, aUp, aLoad;
  logic [3:0] aLoadVal, aQ, aQn;
  logic       aTc, aWrap;

  logic       bEn, bUp, bLoad;
  logic [3:0] bLoadVal, bQ, bQn;
  logic       bTc, bWrap;

  logic       cEn, cUp, cLoad;
  logic [2:0] cLoadVal, cQ, cQn;
  logic       cTc, cWrap;

  int compared   = 0;
  int mismatched = 0;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .en(aEn), .up(aUp), .load(aLoad), .load_val(aLoadVal),
    .q(aQ), .qn(aQn), .tc(aTc), .wrap(aWrap)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1'b1)) dutSat (
    .clk(clk), .reset(reset), .en(bEn), .up(bUp), .load(bLoad), .load_val(bLoadVal),
    .q(bQ), .qn(bQn), .tc(bTc), .wrap(bWrap)
  );

  tff_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0), .SATURATE(1'b0)) dut8 (
    .clk(clk), .reset(reset), .en(cEn), .up(cUp), .load(cLoad), .load_val(cLoadVal),
    .q(cQ), .qn(cQn), .tc(cTc), .wrap(cWrap)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic up, input logic load,
                               input logic [3:0] loadVal);
    aEn      = en;
    aUp      = up;
    aLoad    = load;
    aLoadVal = loadVal;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input int expQ, input logic expWrap,
                        input logic expTc);
    checkOutput({tag, "_q"}, 32'(aQ), 32'(expQ));
    checkOutput({tag, "_qn"}, 32'(aQn), 32'((~expQ) & 4'hF));
    checkOutput({tag, "_wrap"}, 32'(aWrap), 32'(expWrap));
    checkOutput({tag, "_tc"}, 32'(aTc), 32'(expTc));
  endtask

  initial begin
    int   expQ;
    logic expWrap;
    int   wrapCount;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    bEn = 1'b0; bUp = 1'b1; bLoad = 1'b0; bLoadVal = 4'd0;
    cEn = 1'b0; cUp = 1'b1; cLoad = 1'b0; cLoadVal = 3'd0;

    #2;
    checkA("reset", 0, 1'b0, 1'b0);
    aUp = 1'b0;
    #1;
    checkOutput("reset_tc_down", 32'(aTc), 32'd1);
    aUp = 1'b1;
    #20;
    reset = 1'b0;

    // Wrapping up-count through 9 -> 0
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    expQ = 0;
    for (int k = 0; k < 12; k++) begin
      expWrap = (expQ == 9);
      expQ    = (expQ + 1) % 10;
      tick();
      checkA($sformatf("up%0d", k), expQ, expWrap, expQ == 9);
    end

    // Wrapping down-count from 0
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    checkA("load0", 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    checkOutput("tc_dir_change", 32'(aTc), 32'd1);
    tick();
    checkA("dn0", 9, 1'b1, 1'b0);
    tick();
    checkA("dn1", 8, 1'b0, 1'b0);
    tick();
    checkA("dn2", 7, 1'b0, 1'b0);

    // Load priority and clamping
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd6);
    tick();
    checkA("load6", 6, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd13);
    tick();
    checkA("load13_clamp", 9, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checkOutput("tc_no_en", 32'(aTc), 32'd1);

    // Asynchronous reset mid-cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5);
    tick();
    checkA("load5", 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    #3;
    reset = 1'b1;
    #1;
    checkA("async_rst", 0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    checkA("post_rst", 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);

    // Saturating instance
    bLoad = 1'b1; bLoadVal = 4'd7; bEn = 1'b1; bUp = 1'b1;
    tick();
    checkOutput("sat_load7", 32'(bQ), 32'd7);
    bLoad = 1'b0;
    expQ = 7;
    for (int k = 0; k < 4; k++) begin
      expQ = (expQ < 9) ? expQ + 1 : 9;
      tick();
      checkOutput($sformatf("sat_up%0d_q", k), 32'(bQ), 32'(expQ));
      checkOutput($sformatf("sat_up%0d_wrap", k), 32'(bWrap), 32'd0);
    end
    checkOutput("sat_tc", 32'(bTc), 32'd1);
    bUp = 1'b0;
    tick();
    checkOutput("sat_dn_q", 32'(bQ), 32'd8);
    bLoad = 1'b1; bLoadVal = 4'd0;
    tick();
    bLoad = 1'b0;
    tick();
    checkOutput("sat_floor_q", 32'(bQ), 32'd0);
    checkOutput("sat_floor_wrap", 32'(bWrap), 32'd0);
    bEn = 1'b0;

    // Power-of-two modulus
    cEn = 1'b1; cUp = 1'b1;
    expQ = 0;
    wrapCount = 0;
    for (int k = 0; k < 16; k++) begin
      if (expQ == 7) checkOutput($sformatf("p2_toggle%0d", k), 32'(dut8.toggleVec), 32'd7);
      expWrap = (expQ == 7);
      expQ    = (expQ + 1) % 8;
      tick();
      if (cWrap) wrapCount++;
      checkOutput($sformatf("p2_up%0d_q", k), 32'(cQ), 32'(expQ));
      checkOutput($sformatf("p2_up%0d_wrap", k), 32'(cWrap), 32'(expWrap));
    end
    checkOutput("p2_wrap_count", 32'(wrapCount), 32'd2);
    cEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
